ps2_key_tracker: RTL

//  Consumes scan-code bytes from the ps2_keyboard receiver and decodes make, break (F0) and extended (E0) sequences.

---
 rtl/ps2_pkg.sv | 22 ++
 rtl/ps2_held_table.sv | 71 +++++++
 rtl/ps2_key_tracker.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ps2_pkg
// Brief    : Shared constants and types for the PS/2 key tracker.
// Revision : 1.0
// ============================================================================
package ps2_pkg;

  localparam logic [7:0] PS2_BRK = 8'hF0;
  localparam logic [7:0] PS2_EXT = 8'hE0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_POP    = 2'd1,
    ST_SETTLE = 2'd2
  } pop_state_e;

  // {ext, scan code}
  typedef logic [8:0] key_code_t;

endpackage
`default_nettype wire

// File: rtl/ps2_held_table.sv
`default_nettype none
// ============================================================================
// Module   : ps2_held_table
// Brief    : Small CAM of currently held key codes; inserts at lowest free slot.
// Revision : 1.0
// ============================================================================
module ps2_held_table
  import ps2_pkg::*;
#(
  parameter int MAX_KEYS = 4
) (
  input  logic                           clk,
  input  logic                           clr,
  input  key_code_t                      code_i,
  input  logic                           insert_i,
  input  logic                           remove_i,
  output logic                           hit_o,
  output logic                           full_o,
  output logic [$clog2(MAX_KEYS+1)-1:0]  count_o
);

  localparam int COUNT_W = $clog2(MAX_KEYS + 1);

  logic [MAX_KEYS-1:0] valid_q;
  logic [MAX_KEYS-1:0] valid_d;
  logic [MAX_KEYS-1:0] match;
  logic [MAX_KEYS-1:0] free_oh;
  logic                do_insert;
  key_code_t           codes_q [MAX_KEYS];

  generate
    for (genvar i = 0; i < MAX_KEYS; i++) begin : g_match
      assign match[i] = valid_q[i] && (codes_q[i] == code_i);
    end
  endgenerate

  // Isolates the lowest clear bit of the valid vector.
  assign free_oh   = ~valid_q & (valid_q + MAX_KEYS'(1));
  assign hit_o     = |match;
  assign full_o    = &valid_q;
  assign do_insert = insert_i & ~hit_o & ~full_o;

  always_comb begin
    valid_d = valid_q;
    if (do_insert) valid_d = valid_d | free_oh;
    if (remove_i)  valid_d = valid_d & ~match;
  end

  always_ff @(posedge clk) begin
    if (clr) valid_q <= '0;
    else     valid_q <= valid_d;
  end

  generate
    for (genvar i = 0; i < MAX_KEYS; i++) begin : g_entry
      always_ff @(posedge clk) begin
        if (clr)                           codes_q[i] <= '0;
        else if (do_insert && free_oh[i])  codes_q[i] <= code_i;
      end
    end
  endgenerate

  always_comb begin
    count_o = '0;
    for (int i = 0; i < MAX_KEYS; i++) begin
      count_o = count_o + COUNT_W'(valid_q[i]);
    end
  end

endmodule
`default_nettype wire

// File: rtl/ps2_key_tracker.sv
`default_nettype none
// ============================================================================
// Module   : ps2_key_tracker
// Brief    : Pops PS/2 scan bytes, decodes make/break/extended sequences and
//            tracks held keys. Optional macro PS2_EXT_CODE_EN honours E0.
// Revision : 1.0
// ============================================================================
module ps2_key_tracker
  import ps2_pkg::*;
#(
  parameter int MAX_KEYS = 4,
  parameter int CNT_W    = 8
) (
  input  logic                           clk,
  input  logic                           clr,
  input  logic [7:0]                     kb_data,
  input  logic                           kb_ready,
  input  logic                           kb_overflow,
  output logic                           kb_nextdata_n,
  output logic                           evt_valid,
  output logic                           evt_make,
  output logic                           evt_repeat,
  output logic [8:0]                     evt_code,
  output logic [7:0]                     disp_code,
  output logic [$clog2(MAX_KEYS+1)-1:0]  held_count,
  output logic                           held_full,
  output logic [CNT_W-1:0]               press_count,
  output logic                           ovf_seen
);

  pop_state_e       state_q, state_d;
  logic [7:0]       byte_q, byte_d;
  logic             brk_q, brk_d;
  logic             ext_q, ext_d;
  logic             evt_valid_q, evt_valid_d;
  logic             evt_make_q, evt_make_d;
  logic             evt_repeat_q, evt_repeat_d;
  key_code_t        evt_code_q, evt_code_d;
  key_code_t        disp_key_q, disp_key_d;
  logic [CNT_W-1:0] press_q, press_d;
  logic             held_full_q, held_full_d;
  logic             ovf_q, ovf_d;

  logic             pop;
  logic             is_brk;
  logic             is_ext;
  logic             is_key;
  logic             do_make;
  logic             do_break;
  key_code_t        key;
  logic             tbl_hit;
  logic             tbl_full;

  assign pop      = (state_q == ST_POP);
  assign is_brk   = (byte_q == PS2_BRK);
  assign is_ext   = (byte_q == PS2_EXT);
  assign is_key   = pop & ~is_brk & ~is_ext;
  assign do_make  = is_key & ~brk_q;
  assign do_break = is_key & brk_q;
  assign key      = {ext_q, byte_q};

  ps2_held_table #(
    .MAX_KEYS (MAX_KEYS)
  ) u_table (
    .clk      (clk),
    .clr      (clr),
    .code_i   (key),
    .insert_i (do_make),
    .remove_i (do_break),
    .hit_o    (tbl_hit),
    .full_o   (tbl_full),
    .count_o  (held_count)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= ST_IDLE;
      byte_q  <= '0;
    end else begin
      state_q <= state_d;
      byte_q  <= byte_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    byte_d        = byte_q;
    kb_nextdata_n = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (kb_ready) begin
          byte_d  = kb_data;
          state_d = ST_POP;
        end
      end
      ST_POP: begin
        kb_nextdata_n = 1'b0;
        state_d       = ST_SETTLE;
      end
      ST_SETTLE: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    brk_d        = brk_q;
    ext_d        = ext_q;
    evt_valid_d  = 1'b0;
    evt_make_d   = 1'b0;
    evt_repeat_d = 1'b0;
    evt_code_d   = '0;
    disp_key_d   = disp_key_q;
    press_d      = press_q;
    held_full_d  = held_full_q;
    ovf_d        = ovf_q | kb_overflow;

    if (is_key) begin
      evt_valid_d  = 1'b1;
      evt_make_d   = ~brk_q;
      evt_repeat_d = ~brk_q & tbl_hit;
      evt_code_d   = key;
      brk_d        = 1'b0;
      ext_d        = 1'b0;
    end
    if (pop && is_brk) brk_d = 1'b1;
`ifdef PS2_EXT_CODE_EN
    if (pop && is_ext) ext_d = 1'b1;
`endif

    // A full-table make still counts as a press but never reaches the display.
    if (do_make) begin
      if (tbl_hit || !tbl_full) disp_key_d  = key;
      if (!tbl_hit)             press_d     = press_q + CNT_W'(1);
      if (!tbl_hit && tbl_full) held_full_d = 1'b1;
    end
    if (do_break && tbl_hit && (disp_key_q == key)) disp_key_d = '0;

    if (kb_overflow) begin
      brk_d = 1'b0;
      ext_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      brk_q        <= 1'b0;
      ext_q        <= 1'b0;
      evt_valid_q  <= 1'b0;
      evt_make_q   <= 1'b0;
      evt_repeat_q <= 1'b0;
      evt_code_q   <= '0;
      disp_key_q   <= '0;
      press_q      <= '0;
      held_full_q  <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      brk_q        <= brk_d;
      ext_q        <= ext_d;
      evt_valid_q  <= evt_valid_d;
      evt_make_q   <= evt_make_d;
      evt_repeat_q <= evt_repeat_d;
      evt_code_q   <= evt_code_d;
      disp_key_q   <= disp_key_d;
      press_q      <= press_d;
      held_full_q  <= held_full_d;
      ovf_q        <= ovf_d;
    end
  end

  assign evt_valid   = evt_valid_q;
  assign evt_make    = evt_make_q;
  assign evt_repeat  = evt_repeat_q;
  assign evt_code    = evt_code_q;
  assign disp_code   = disp_key_q[7:0];
  assign held_full   = held_full_q;
  assign press_count = press_q;
  assign ovf_seen    = ovf_q;

endmodule
`default_nettype wire
